// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with integrated load-use hazard detection.
// Captures decoded operands, specifiers and control from ID each cycle and
// drives EX. A load in EX whose rt feeds the instruction in ID raises
// hazard_stall_o and squashes one bubble into ID/EX.
// Optional feature macro: ID_EX_PERF_EN adds a saturating 32-bit bubble
// counter on bubble_cnt_o; without it the port and counter are absent.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          mem_stall_i,
  input  logic          flush_i,
  input  logic [RW-1:0] ifid_rs_i,
  input  logic [RW-1:0] ifid_rt_i,
  input  logic [RW-1:0] ifid_rd_i,
  input  logic [DW-1:0] rs_data_i,
  input  logic [DW-1:0] rt_data_i,
  input  logic [DW-1:0] imm_i,
  input  logic          reg_write_i,
  input  logic          mem_to_reg_i,
  input  logic          mem_read_i,
  input  logic          mem_write_i,
  input  logic          alu_src_i,
  input  logic          reg_dst_i,
  input  logic [1:0]    alu_op_i,
  output logic [RW-1:0] rs_o,
  output logic [RW-1:0] rt_o,
  output logic [RW-1:0] rd_o,
  output logic [DW-1:0] rs_data_o,
  output logic [DW-1:0] rt_data_o,
  output logic [DW-1:0] imm_o,
  output logic          reg_write_o,
  output logic          mem_to_reg_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic          alu_src_o,
  output logic          reg_dst_o,
  output logic [1:0]    alu_op_o,
  output logic          hazard_stall_o
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]   bubble_cnt_o
`endif
);

  logic [RW-1:0] r_rs, r_rt, r_rd;
  logic [DW-1:0] r_rs_data, r_rt_data, r_imm;
  logic          r_reg_write, r_mem_to_reg, r_mem_read, r_mem_write;
  logic          r_alu_src, r_reg_dst;
  logic [1:0]    r_alu_op;
  logic          w_hazard;
  logic          w_bubble;

  // Load-use detect: the load in EX writes rt; register 0 never matches.
  always_comb begin
    w_hazard = r_mem_read && (r_rt != '0) &&
               ((r_rt == ifid_rs_i) || (r_rt == ifid_rt_i));
    w_bubble = !mem_stall_i && (flush_i || w_hazard);
  end

  // Pipeline register: hold on memory stall, zero on bubble, else load ID.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_alu_op     <= '0;
    end else if (mem_stall_i) begin
      r_rs         <= r_rs;
      r_rt         <= r_rt;
      r_rd         <= r_rd;
      r_rs_data    <= r_rs_data;
      r_rt_data    <= r_rt_data;
      r_imm        <= r_imm;
      r_reg_write  <= r_reg_write;
      r_mem_to_reg <= r_mem_to_reg;
      r_mem_read   <= r_mem_read;
      r_mem_write  <= r_mem_write;
      r_alu_src    <= r_alu_src;
      r_reg_dst    <= r_reg_dst;
      r_alu_op     <= r_alu_op;
    end else if (w_bubble) begin
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_alu_op     <= '0;
    end else begin
      r_rs         <= ifid_rs_i;
      r_rt         <= ifid_rt_i;
      r_rd         <= ifid_rd_i;
      r_rs_data    <= rs_data_i;
      r_rt_data    <= rt_data_i;
      r_imm        <= imm_i;
      r_reg_write  <= reg_write_i;
      r_mem_to_reg <= mem_to_reg_i;
      r_mem_read   <= mem_read_i;
      r_mem_write  <= mem_write_i;
      r_alu_src    <= alu_src_i;
      r_reg_dst    <= reg_dst_i;
      r_alu_op     <= alu_op_i;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] r_bubble_cnt;

  // Count every bubble edge (hazard or flush), saturating at all-ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
`endif

  assign rs_o           = r_rs;
  assign rt_o           = r_rt;
  assign rd_o           = r_rd;
  assign rs_data_o      = r_rs_data;
  assign rt_data_o      = r_rt_data;
  assign imm_o          = r_imm;
  assign reg_write_o    = r_reg_write;
  assign mem_to_reg_o   = r_mem_to_reg;
  assign mem_read_o     = r_mem_read;
  assign mem_write_o    = r_mem_write;
  assign alu_src_o      = r_alu_src;
  assign reg_dst_o      = r_reg_dst;
  assign alu_op_o       = r_alu_op;
  assign hazard_stall_o = w_hazard;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the 5-stage MIPS core, with integrated load-use hazard detection. It captures decoded operands, register specifiers and control bits from the ID stage every cycle. It drives the EX stage, including the Rs/Rt specifiers that the forwarding unit compares against EX/MEM.Rd and MEM/WB.Rd. When a load in EX feeds the instruction in ID, it raises a stall and inserts one bubble.

## Interface
Parameters:
- DW, 32, datapath width for operand and immediate fields
- RW, 5, register specifier width

Ports:
- clk_i  in  1  core clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- mem_stall_i  in  1  global freeze (cache miss); hold all ID/EX contents
- flush_i  in  1  squash instruction currently in ID; load a bubble
- ifid_rs_i / ifid_rt_i / ifid_rd_i  in  RW each  specifiers of the instruction in ID
- rs_data_i / rt_data_i  in  DW each  register file read data
- imm_i  in  DW  sign-extended immediate
- reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, alu_src_i, reg_dst_i  in  1 each  decoded control
- alu_op_i  in  2  ALU op class
- rs_o / rt_o / rd_o  out  RW each  registered specifiers; rs_o and rt_o go to the forwarding unit
- rs_data_o / rt_data_o / imm_o  out  DW each  registered operands
- reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, alu_src_o, reg_dst_o  out  1 each  registered control
- alu_op_o  out  2  registered ALU op class
- hazard_stall_o  out  1  combinational; 1 means hold the PC and IF/ID and squash into ID/EX
- bubble_cnt_o  out  32  bubbles inserted; present only with ID_EX_PERF_EN

## Operation
- Reset (rst_i=0): every registered output clears to 0 immediately, without waiting for a clock edge. hazard_stall_o therefore reads 0 and bubble_cnt_o reads 0.
- Hazard detect (combinational from registered state and ID inputs):
  - hazard_stall_o = mem_read_o && rt_o != 0 && (rt_o == ifid_rs_i || rt_o == ifid_rt_i).
  - No qualification by instruction type. A false stall on an unused rt costs one cycle and is accepted.
- Per-edge update, in priority order:
  1. mem_stall_i=1: HOLD. All registers keep their values; the counter does not increment. flush_i and the hazard are ignored this edge; upstream is also frozen and re-presents next cycle.
  2. flush_i=1 or hazard_stall_o=1: BUBBLE.
     - All control outputs go to 0.
     - rs_o, rt_o, rd_o go to 0, so the forwarding unit and the next hazard check see register 0 and never match.
     - rs_data_o, rt_data_o, imm_o go to 0.
  3. Otherwise: LOAD. Every *_i field is copied to its *_o counterpart.
- Self-clearing: after a BUBBLE, mem_read_o=0, so hazard_stall_o falls. A single load-use costs exactly one stall cycle, and two back-to-back hazards from one load are impossible.
- Effective state is two-valued: VALID (contents from LOAD) and BUBBLE (all-zero). HOLD preserves whichever is current. Reset enters BUBBLE.

## Timing
- Latency: one cycle, ID inputs at edge n appear on outputs after edge n.
- hazard_stall_o is valid in the same cycle the dependent instruction sits in ID, with no registered delay. Upstream must sample it before the next edge.
- Load-use sequence:
  - lw latched at edge n.
  - The dependent instruction in ID during cycle n+1 raises hazard_stall_o.
  - The bubble is latched at edge n+1 while IF/ID holds.
  - The dependent instruction is loaded at edge n+2. The lw is then in MEM/WB, reachable by the forwarding unit's MEM/WB path.
- Asynchronous assertion of rst_i mid-stall clears hazard_stall_o in the same cycle. Deassertion is synchronised externally; the first edge after release performs LOAD.

## Configuration
- ID_EX_PERF_EN defined:
  - Adds 32-bit bubble_cnt_o.
  - Increments by 1 on every edge that performs BUBBLE, both hazard- and flush-induced, and is otherwise unchanged.
  - Saturates at 0xFFFF_FFFF and does not wrap.
  - Cleared by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Reset mid-operation: outputs loaded with reg_write_o=1, rd_o=7; drive rst_i=0 between edges -> all outputs 0 before the next edge; hazard_stall_o=0.
- Pass-through: ifid_rs_i=5, rt=6, rd=7, rs_data_i=0x11, reg_write_i=1 -> after one edge rs_o=5, rt_o=6, rd_o=7, rs_data_o=0x11, reg_write_o=1; hazard_stall_o=0 throughout.
- Load-use: lw with rt=8, mem_read=1 latched; ID presents ifid_rs_i=8 -> hazard_stall_o=1 that cycle; next edge gives all-zero outputs and hazard_stall_o=0; following edge loads rs_o=8.
- Register-0 load: latched mem_read_o=1, rt_o=0; ID has ifid_rs_i=0 -> hazard_stall_o stays 0, normal LOAD.
- Priority: mem_stall_i=1 together with flush_i=1 and an active hazard -> outputs unchanged across the edge. mem_stall_i=0 next cycle with flush_i=1 -> BUBBLE.
- With ID_EX_PERF_EN: 3 hazard bubbles plus 2 flushes plus 1 held cycle -> bubble_cnt_o=5. Counter preloaded via force to 0xFFFF_FFFF plus one bubble -> stays 0xFFFF_FFFF.
